// File: rtl/fifo_sync.sv
// Single-clock synchronous FIFO with registered read data and
// occupancy-decoded empty/almost_empty/almost_full/full flags.
module fifo_sync #(
    parameter int DATA_WIDTH         = 8,
    parameter int FIFO_DEPTH         = 32,
    parameter int ALMOST_EMPTY_LEVEL = 2,
    parameter int ALMOST_FULL_LEVEL  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data_out
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] LVL_AE   = (AW+1)'(ALMOST_EMPTY_LEVEL);
    localparam logic [AW:0] LVL_AF   = (AW+1)'(FIFO_DEPTH - ALMOST_FULL_LEVEL);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wptr, rptr;
    logic [AW:0]           count;
    logic                  wr_acc, rd_acc;

    // A write into a full FIFO is allowed only when a read frees a slot this cycle.
    assign rd_acc = rd && !empty;
    assign wr_acc = wr && (!full || rd_acc);

    assign empty        = (count == '0);
    assign almost_empty = (count <= LVL_AE);
    assign almost_full  = (count >= LVL_AF);
    assign full         = (count == LVL_FULL);

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (wr_acc)
                wptr <= wptr + AW'(1);
            if (rd_acc) begin
                data_out <= mem[rptr];
                rptr     <= rptr + AW'(1);
            end
            if (wr_acc && !rd_acc)
                count <= count + (AW+1)'(1);
            else if (rd_acc && !wr_acc)
                count <= count - (AW+1)'(1);
        end
    end
endmodule

// File: tb/tb_fifo_sync.sv
// Directed and model-based bench for fifo_sync (8-bit x 32, levels 2/2).
module tb_fifo_sync;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr = 1'b0, rd = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       empty, almost_empty, almost_full, full;
    logic [7:0] data_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] exp_dout = 8'h00;

    fifo_sync #(.DATA_WIDTH(8), .FIFO_DEPTH(32), .ALMOST_EMPTY_LEVEL(2), .ALMOST_FULL_LEVEL(2)) dut (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .data_in(data_in),
        .empty(empty), .almost_empty(almost_empty), .almost_full(almost_full),
        .full(full), .data_out(data_out)
    );

    always #5 clk = ~clk;

    // {empty, almost_empty, almost_full, full} for a given occupancy
    function automatic logic [3:0] exp_flags(input int n);
        return {n == 0, n <= 2, n >= 30, n == 32};
    endfunction

    function automatic logic [3:0] flags();
        return {empty, almost_empty, almost_full, full};
    endfunction

    // One clock with the given request; reference queue tracks what should be accepted.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        bit racc, wacc;
        racc = r && (q.size() != 0);
        wacc = w && (q.size() < 32 || racc);
        wr = w; rd = r; data_in = d;
        @(posedge clk); #1;
        if (racc) exp_dout = q.pop_front();
        if (wacc) q.push_back(d);
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        checks++;
        if (flags() !== 4'b1100) begin
            errors++; $display("FAIL reset_flags got %b want 1100", flags());
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++; $display("FAIL reset_dout got %h want 00", data_out);
        end
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'hC0 + 8'(i));
        cyc(1'b1, 1'b1, 8'hC5);  // leaves data_out = C0, count 5
        #3 rst = 1'b0;
        #1;
        checks++;
        if (flags() !== 4'b1100) begin
            errors++; $display("FAIL midreset_flags got %b want 1100", flags());
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++; $display("FAIL midreset_dout got %h want 00", data_out);
        end
        @(negedge clk) rst = 1'b1;
        q.delete(); exp_dout = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        for (int n = 1; n <= 32; n++) begin
            cyc(1'b1, 1'b0, 8'(n));
            checks++;
            if (flags() !== exp_flags(n)) begin
                errors++; $display("FAIL fill_flags n=%0d got %b want %b", n, flags(), exp_flags(n));
            end
        end
        cyc(1'b1, 1'b0, 8'hFF);
        checks++;
        if (flags() !== 4'b0011) begin
            errors++; $display("FAIL fill_overflow_flags got %b want 0011", flags());
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 32; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            checks++;
            if (data_out !== 8'(i)) begin
                errors++; $display("FAIL drain_data i=%0d got %h want %h", i, data_out, 8'(i));
            end
            checks++;
            if (flags() !== exp_flags(32 - i)) begin
                errors++; $display("FAIL drain_flags i=%0d got %b want %b", i, flags(), exp_flags(32 - i));
            end
        end
        cyc(1'b0, 1'b1, 8'h00);
        checks++;
        if (data_out !== 8'h20 || flags() !== 4'b1100) begin
            errors++; $display("FAIL underflow got %h/%b want 20/1100", data_out, flags());
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_seq [6] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'hAA, 8'h00};
        // mid-occupancy: count 5 stays 5, oldest word out
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h10 + 8'(i));
        cyc(1'b1, 1'b1, 8'hAA);
        checks++;
        if (data_out !== 8'h10 || flags() !== 4'b0000) begin
            errors++; $display("FAIL simul_mid got %h/%b want 10/0000", data_out, flags());
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            checks++;
            if (data_out !== exp_seq[i]) begin
                errors++; $display("FAIL simul_mid_drain i=%0d got %h want %h", i, data_out, exp_seq[i]);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++; $display("FAIL simul_mid_empty got %b want 1", empty);
        end
        // full: both accepted, full holds
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, 8'h40 + 8'(i));
        cyc(1'b1, 1'b1, 8'hBB);
        checks++;
        if (data_out !== 8'h40 || full !== 1'b1) begin
            errors++; $display("FAIL simul_full got %h/%b want 40/1", data_out, full);
        end
        for (int i = 1; i <= 32; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            checks++;
            if (data_out !== ((i == 32) ? 8'hBB : 8'h40 + 8'(i))) begin
                errors++; $display("FAIL simul_full_drain i=%0d got %h want %h", i, data_out,
                                   (i == 32) ? 8'hBB : 8'h40 + 8'(i));
            end
        end
        // empty: only the write lands, data_out holds BB
        cyc(1'b1, 1'b1, 8'h55);
        checks++;
        if (data_out !== 8'hBB || flags() !== 4'b0100) begin
            errors++; $display("FAIL simul_empty got %h/%b want BB/0100", data_out, flags());
        end
        cyc(1'b0, 1'b1, 8'h00);
        checks++;
        if (data_out !== 8'h55 || empty !== 1'b1) begin
            errors++; $display("FAIL simul_empty_drain got %h/%b want 55/1", data_out, empty);
        end
    endtask

    task automatic test_wrap();
        int plan_w [4] = '{20, 0, 32, 0};
        int plan_r [4] = '{0, 20, 0, 32};
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < plan_w[p] + plan_r[p]; k++) begin
                cyc(plan_w[p] != 0, plan_r[p] != 0, 8'($urandom_range(0, 255)));
                checks++;
                if (data_out !== exp_dout || flags() !== exp_flags(q.size())) begin
                    errors++; $display("FAIL wrap p=%0d k=%0d got %h/%b want %h/%b", p, k,
                                       data_out, flags(), exp_dout, exp_flags(q.size()));
                end
            end
        end
    endtask

    task automatic test_stress();
        int bad = 0;
        for (int c = 0; c < 10000; c++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            checks++;
            if (data_out !== exp_dout || flags() !== exp_flags(q.size())) begin
                errors++;
                if (bad < 10)
                    $display("FAIL stress c=%0d got %h/%b want %h/%b", c,
                             data_out, flags(), exp_dout, exp_flags(q.size()));
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_stress();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
- Single-clock synchronous FIFO buffering DATA_WIDTH-bit words, FIFO_DEPTH entries deep, between a producer and a consumer in the same clock domain.
- Provides empty, almost_empty, almost_full and full status flags.
- Read data is registered.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- FIFO_DEPTH, 32, number of storage entries; must be a power of 2 and at least 4.
- ALMOST_EMPTY_LEVEL, 2, almost_empty is asserted while occupancy <= this value.
- ALMOST_FULL_LEVEL, 2, almost_full is asserted while occupancy >= FIFO_DEPTH - this value.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-low: 0 resets immediately, release is synchronous to clk by use.
- wr  input  1  write request, sampled at the rising edge of clk.
- rd  input  1  read request, sampled at the rising edge of clk.
- data_in  input  DATA_WIDTH  write data, captured with an accepted write.
- empty  output  1  occupancy == 0.
- almost_empty  output  1  occupancy <= ALMOST_EMPTY_LEVEL.
- almost_full  output  1  occupancy >= FIFO_DEPTH - ALMOST_FULL_LEVEL.
- full  output  1  occupancy == FIFO_DEPTH.
- data_out  output  DATA_WIDTH  registered read data.

Behaviour:
- State: memory array [FIFO_DEPTH], write pointer, read pointer (log2(FIFO_DEPTH) bits each), occupancy counter (log2(FIFO_DEPTH)+1 bits).
- Reset (rst=0, asynchronous):
  - pointers = 0, count = 0, data_out = 0.
  - empty=1, almost_empty=1, almost_full=0, full=0.
  - Memory contents are not cleared.
- Accepted write: wr=1 and (full=0, or rd is also accepted in the same cycle). Effects: mem[wptr] <= data_in; wptr increments.
- Accepted read: rd=1 and empty=0. Effects: data_out <= mem[rptr]; rptr increments.
- Read latency: data_out shows the oldest word on the rising edge that accepts rd. data_out holds its value in all other cycles, including rejected reads.
- Pointers wrap from FIFO_DEPTH-1 to 0 through natural binary overflow.
- count update: +1 for write only, -1 for read only, unchanged for both or neither.
- Flags are decoded combinationally from the registered count, so they change only after a clock edge or reset.
- Boundary cases:
  - Write when full with no read: ignored; no state change, no error flag.
  - Read when empty: ignored; data_out unchanged.
  - Simultaneous wr and rd when full: both accepted; count stays FIFO_DEPTH; full stays 1.
  - Simultaneous wr and rd when empty: only the write is accepted; count becomes 1; data_out unchanged.
  - Simultaneous wr and rd otherwise: both accepted; order is preserved; count unchanged.
- Reset mid-operation: all stored data is discarded immediately; the FIFO returns to the reset state regardless of clk.
- No combinational path from wr, rd or data_in to any output.
- Ordering: strict first-in first-out; no reordering or duplication.

Test Plan:
- Reset check: hold rst=0 for 2 cycles with wr=rd=0, then release. Required: empty=1, almost_empty=1, almost_full=0, full=0, data_out=0. Then assert rst=0 mid-cycle with 5 words stored: empty=1 immediately.
- Fill: write 32 distinct words 0x01..0x20 with rd=0. Required flags:
  - almost_empty drops after write 3.
  - almost_full rises after write 30.
  - full=1 after write 32.
  - A 33rd write of 0xFF is ignored; count stays 32.
- Drain: issue 32 reads from the full FIFO. Required:
  - data_out sequence 0x01..0x20 in order.
  - full clears after the first read; almost_full clears at count 29; almost_empty sets at count 2; empty=1 after read 32.
  - A 33rd read leaves data_out=0x20.
- Simultaneous ops:
  - At count 5, assert wr=rd=1 with data_in=0xAA: count stays 5 and data_out is the oldest word.
  - When full, assert wr=rd=1: full stays 1 and the new word is emitted after the 31 older words.
  - When empty, assert wr=rd=1 with data_in=0x55: count=1, empty=0, data_out unchanged.
- Wrap-around: write 20, read 20, write 32 random words, read 32. Required: every word matches a scoreboard model and no flag mismatches occur across the pointer wrap.
- Random stress: 10,000 cycles of random wr/rd with about 50% probability each. Required: data_out and all four flags match a reference queue model every cycle.
